// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks HI/LO occupancy for MD_LATENCY cycles after a mult/div issues in EX.
module md_busy_tracker
  import pipe_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic clk,
  input  logic CLR,
  input  logic halt,
  input  logic start,
  output logic busy
);

  localparam int unsigned CNT_BITS = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;

  md_state_t           state;
  md_state_t           state_nxt;
  logic [CNT_BITS-1:0] cnt;
  logic [CNT_BITS-1:0] cnt_nxt;

  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A new start always reloads the full latency, even while already busy.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!halt) begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            state_nxt = MD_BUSY;
            cnt_nxt   = CNT_BITS'(MD_LATENCY - 1);
          end
        end
        MD_BUSY: begin
          if (start) begin
            cnt_nxt = CNT_BITS'(MD_LATENCY - 1);
          end else if (cnt == '0) begin
            state_nxt = MD_IDLE;
          end else begin
            cnt_nxt = cnt - CNT_BITS'(1);
          end
        end
        default: state_nxt = MD_IDLE;
      endcase
    end
  end

  assign busy = (state == MD_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline.
// Define HAZARD_FWD_EN to enable EX operand forwarding (load-use stall only).
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  CLR,
  input  logic                  halt,
  input  logic                  id_r1_used,
  input  logic                  id_r2_used,
  input  logic                  id_hi_used,
  input  logic                  id_lo_used,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_to_reg,
  input  logic [REG_ADDR_W-1:0] ex_wb_reg,
  input  logic [1:0]            ex_hilo_write,
  input  logic                  ex_md_start,
  input  logic                  ex_branch_taken,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_wb_reg,
  input  logic [1:0]            mem_hilo_write,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  bubble_ex,
  output logic                  flush_id,
  output fwd_sel_t              fwd_a_sel,
  output fwd_sel_t              fwd_b_sel,
  output logic                  md_busy,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  logic     ex_m1, ex_m2, mem_m1, mem_m2;
  logic     hilo_haz, load_use, gpr_haz, raw;
  fwd_sel_t fwd_a_nxt, fwd_b_nxt;

  md_busy_tracker #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md (
    .clk  (clk),
    .CLR  (CLR),
    .halt (halt),
    .start(ex_md_start),
    .busy (md_busy)
  );

  // Source/writer matches; WB writers are covered by the write-through register file.
  always_comb begin
    ex_m1  = id_r1_used && (id_rs != '0) && ex_reg_write  && (id_rs == ex_wb_reg);
    ex_m2  = id_r2_used && (id_rt != '0) && ex_reg_write  && (id_rt == ex_wb_reg);
    mem_m1 = id_r1_used && (id_rs != '0) && mem_reg_write && (id_rs == mem_wb_reg);
    mem_m2 = id_r2_used && (id_rt != '0) && mem_reg_write && (id_rt == mem_wb_reg);

    hilo_haz = (id_hi_used && (ex_hilo_write[1] || mem_hilo_write[1]))
            || (id_lo_used && (ex_hilo_write[0] || mem_hilo_write[0]))
            || ((id_hi_used || id_lo_used) && md_busy);
    load_use = ex_mem_to_reg && (ex_m1 || ex_m2);
  end

`ifdef HAZARD_FWD_EN
  always_comb begin
    gpr_haz   = 1'b0;
    fwd_a_nxt = ex_m1 ? FWD_MEM : (mem_m1 ? FWD_WB : FWD_RF);
    fwd_b_nxt = ex_m2 ? FWD_MEM : (mem_m2 ? FWD_WB : FWD_RF);
  end
`else
  always_comb begin
    gpr_haz   = ex_m1 || ex_m2 || mem_m1 || mem_m2;
    fwd_a_nxt = FWD_RF;
    fwd_b_nxt = FWD_RF;
  end
`endif

  // A taken branch squashes the would-be stalled instruction, so flush wins.
  always_comb begin
    raw       = load_use || gpr_haz || hilo_haz;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    if (ex_branch_taken) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (raw) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
    end else if (bubble_ex) begin
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
    end else begin
      fwd_a_sel <= fwd_a_nxt;
      fwd_b_sel <= fwd_b_nxt;
    end
  end

  // Saturating event counters, frozen during halt.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!halt) begin
      if (stall_id && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_id && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (MD_LATENCY=4, CNT_W=4); honours HAZARD_FWD_EN.
module tb_pipe_hazard_ctrl;

  localparam int E_RF  = 0;
  localparam int E_MEM = 1;
  localparam int E_WB  = 2;

  typedef struct {
    string name;
    int    st;
    int    bu;
    int    fl;
    int    fa;
    int    fb;
    int    mb;
    int    sc;
    int    fc;
  } exp_t;

  logic       clk, CLR, halt;
  logic       id_r1_used, id_r2_used, id_hi_used, id_lo_used;
  logic [4:0] id_rs, id_rt, ex_wb_reg, mem_wb_reg;
  logic       ex_reg_write, ex_mem_to_reg, ex_md_start, ex_branch_taken, mem_reg_write;
  logic [1:0] ex_hilo_write, mem_hilo_write;
  logic       stall_if, stall_id, bubble_ex, flush_id, md_busy;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [3:0] stall_cnt, flush_cnt;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  pipe_hazard_ctrl #(
    .REG_ADDR_W(5),
    .MD_LATENCY(4),
    .CNT_W     (4)
  ) dut (
    .clk            (clk),
    .CLR            (CLR),
    .halt           (halt),
    .id_r1_used     (id_r1_used),
    .id_r2_used     (id_r2_used),
    .id_hi_used     (id_hi_used),
    .id_lo_used     (id_lo_used),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_to_reg  (ex_mem_to_reg),
    .ex_wb_reg      (ex_wb_reg),
    .ex_hilo_write  (ex_hilo_write),
    .ex_md_start    (ex_md_start),
    .ex_branch_taken(ex_branch_taken),
    .mem_reg_write  (mem_reg_write),
    .mem_wb_reg     (mem_wb_reg),
    .mem_hilo_write (mem_hilo_write),
    .stall_if       (stall_if),
    .stall_id       (stall_id),
    .bubble_ex      (bubble_ex),
    .flush_id       (flush_id),
    .fwd_a_sel      (fwd_a_sel),
    .fwd_b_sel      (fwd_b_sel),
    .md_busy        (md_busy),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input int act, input int want);
    if (want >= 0) begin
      n_cmp++;
      if (act != want) begin
        n_bad++;
        $display("FAIL %s.%s: got %0d required %0d", nm, fld, act, want);
      end
    end
  endtask

  // Monitor: every presented cycle is checked against the oldest queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.name, "stall_if",  int'(stall_if),  e.st);
      chk(e.name, "stall_id",  int'(stall_id),  e.st);
      chk(e.name, "bubble_ex", int'(bubble_ex), e.bu);
      chk(e.name, "flush_id",  int'(flush_id),  e.fl);
      chk(e.name, "fwd_a_sel", int'(fwd_a_sel), e.fa);
      chk(e.name, "fwd_b_sel", int'(fwd_b_sel), e.fb);
      chk(e.name, "md_busy",   int'(md_busy),   e.mb);
      chk(e.name, "stall_cnt", int'(stall_cnt), e.sc);
      chk(e.name, "flush_cnt", int'(flush_cnt), e.fc);
    end
  end

  task automatic pushx(input string n, input int st, input int bu, input int fl, input int fa,
                       input int fb, input int mb, input int sc, input int fc);
    exp_t x;
    x.name = n; x.st = st; x.bu = bu; x.fl = fl; x.fa = fa;
    x.fb = fb; x.mb = mb; x.sc = sc; x.fc = fc;
    sb.push_back(x);
  endtask

  task automatic idle();
    halt = 0; id_r1_used = 0; id_r2_used = 0; id_hi_used = 0; id_lo_used = 0;
    id_rs = '0; id_rt = '0; ex_reg_write = 0; ex_mem_to_reg = 0; ex_wb_reg = '0;
    ex_hilo_write = '0; ex_md_start = 0; ex_branch_taken = 0;
    mem_reg_write = 0; mem_wb_reg = '0; mem_hilo_write = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    CLR = 1'b1;
    idle();
  endtask

  task automatic do_reset();
    cyc();
    CLR = 1'b0;
    pushx("reset", 0, 0, 0, E_RF, E_RF, 0, 0, 0);
  endtask

  initial begin
    CLR = 1'b0;
    idle();

    // Reset while the mult/div tracker is busy
    do_reset();
    cyc(); ex_md_start = 1;
    pushx("md_start", 0, 0, 0, E_RF, E_RF, 0, 0, 0);
    cyc(); id_lo_used = 1;
    pushx("md_busy1", 1, 1, 0, E_RF, E_RF, 1, 0, 0);
    cyc(); id_lo_used = 1;
    pushx("md_busy2", 1, 1, 0, E_RF, E_RF, 1, 1, 0);
    cyc(); id_lo_used = 1; CLR = 1'b0;
    pushx("rst_mid_busy", 0, 0, 0, E_RF, E_RF, 0, 0, 0);
    cyc();
    pushx("post_rst", 0, 0, 0, E_RF, E_RF, 0, 0, 0);

    // GPR writer $7 passing EX then MEM, then $0, then EX/MEM both writing $3
    do_reset();
    cyc(); ex_reg_write = 1; ex_wb_reg = 5'd7; id_r1_used = 1; id_rs = 5'd7;
`ifdef HAZARD_FWD_EN
    pushx("gpr_ex", 0, 0, 0, E_RF, E_RF, 0, 0, 0);
`else
    pushx("gpr_ex", 1, 1, 0, E_RF, E_RF, 0, 0, 0);
`endif
    cyc(); mem_reg_write = 1; mem_wb_reg = 5'd7; id_r1_used = 1; id_rs = 5'd7;
`ifdef HAZARD_FWD_EN
    pushx("gpr_mem", 0, 0, 0, E_MEM, E_RF, 0, 0, 0);
`else
    pushx("gpr_mem", 1, 1, 0, E_RF, E_RF, 0, 1, 0);
`endif
    cyc(); id_r1_used = 1; id_rs = 5'd7;
`ifdef HAZARD_FWD_EN
    pushx("gpr_wb", 0, 0, 0, E_WB, E_RF, 0, 0, 0);
`else
    pushx("gpr_wb", 0, 0, 0, E_RF, E_RF, 0, 2, 0);
`endif
    cyc(); ex_reg_write = 1; ex_wb_reg = 5'd0; id_r1_used = 1; id_rs = 5'd0;
`ifdef HAZARD_FWD_EN
    pushx("gpr_r0", 0, 0, 0, E_RF, E_RF, 0, 0, 0);
`else
    pushx("gpr_r0", 0, 0, 0, E_RF, E_RF, 0, 2, 0);
`endif
    cyc(); ex_reg_write = 1; ex_wb_reg = 5'd3; mem_reg_write = 1; mem_wb_reg = 5'd3;
    id_r2_used = 1; id_rt = 5'd3;
`ifdef HAZARD_FWD_EN
    pushx("gpr_both", 0, 0, 0, E_RF, E_RF, 0, 0, 0);
`else
    pushx("gpr_both", 1, 1, 0, E_RF, E_RF, 0, 2, 0);
`endif
    cyc();
`ifdef HAZARD_FWD_EN
    pushx("gpr_prio", 0, 0, 0, E_RF, E_MEM, 0, 0, 0);
`else
    pushx("gpr_prio", 0, 0, 0, E_RF, E_RF, 0, 3, 0);
`endif

    // Load-use on rt=$5
    do_reset();
    cyc(); ex_reg_write = 1; ex_mem_to_reg = 1; ex_wb_reg = 5'd5; id_r2_used = 1; id_rt = 5'd5;
    pushx("ld_use", 1, 1, 0, E_RF, E_RF, 0, 0, 0);
    cyc(); mem_reg_write = 1; mem_wb_reg = 5'd5; id_r2_used = 1; id_rt = 5'd5;
`ifdef HAZARD_FWD_EN
    pushx("ld_mem", 0, 0, 0, E_RF, E_RF, 0, 1, 0);
`else
    pushx("ld_mem", 1, 1, 0, E_RF, E_RF, 0, 1, 0);
`endif
    cyc(); id_r2_used = 1; id_rt = 5'd5;
`ifdef HAZARD_FWD_EN
    pushx("ld_wb", 0, 0, 0, E_RF, E_WB, 0, 1, 0);
`else
    pushx("ld_wb", 0, 0, 0, E_RF, E_RF, 0, 2, 0);
`endif
    cyc();
`ifdef HAZARD_FWD_EN
    pushx("ld_done", 0, 0, 0, E_RF, E_RF, 0, 1, 0);
`else
    pushx("ld_done", 0, 0, 0, E_RF, E_RF, 0, 2, 0);
`endif

    // mflo behind a mult/div, with halt stretching the busy window; then HI/LO write hazards
    do_reset();
    cyc(); ex_md_start = 1; id_lo_used = 1;
    pushx("md_issue", 0, 0, 0, E_RF, E_RF, 0, 0, 0);
    cyc(); id_lo_used = 1;
    pushx("md_c1", 1, 1, 0, E_RF, E_RF, 1, 0, 0);
    cyc(); id_lo_used = 1;
    pushx("md_c2", 1, 1, 0, E_RF, E_RF, 1, 1, 0);
    cyc(); id_lo_used = 1; halt = 1;
    pushx("md_halt1", 1, 1, 0, E_RF, E_RF, 1, 2, 0);
    cyc(); id_lo_used = 1; halt = 1;
    pushx("md_halt2", 1, 1, 0, E_RF, E_RF, 1, 2, 0);
    cyc(); id_lo_used = 1;
    pushx("md_c3", 1, 1, 0, E_RF, E_RF, 1, 2, 0);
    cyc(); id_lo_used = 1;
    pushx("md_c4", 1, 1, 0, E_RF, E_RF, 1, 3, 0);
    cyc(); id_lo_used = 1;
    pushx("md_free", 0, 0, 0, E_RF, E_RF, 0, 4, 0);
    cyc(); id_hi_used = 1; mem_hilo_write = 2'b10;
    pushx("hi_mem", 1, 1, 0, E_RF, E_RF, 0, 4, 0);
    cyc(); id_hi_used = 1; ex_hilo_write = 2'b01;
    pushx("hi_vs_lo", 0, 0, 0, E_RF, E_RF, 0, 5, 0);
    cyc(); id_lo_used = 1; ex_hilo_write = 2'b01;
    pushx("lo_ex", 1, 1, 0, E_RF, E_RF, 0, 5, 0);
    cyc();
    pushx("hilo_done", 0, 0, 0, E_RF, E_RF, 0, 6, 0);

    // Flush beats stall; counter saturation at 4 bits
    do_reset();
    cyc(); id_lo_used = 1; ex_hilo_write = 2'b01; ex_branch_taken = 1;
    ex_reg_write = 1; ex_wb_reg = 5'd3; id_r1_used = 1; id_rs = 5'd3;
    pushx("br_vs_stall", 0, 1, 1, E_RF, E_RF, 0, 0, 0);
    cyc();
    pushx("br_after", 0, 0, 0, E_RF, E_RF, 0, 0, 1);
    for (int k = 0; k < 20; k++) begin
      cyc(); id_lo_used = 1; ex_hilo_write = 2'b01;
      pushx("sat_stall", 1, 1, 0, E_RF, E_RF, 0, (k > 15) ? 15 : k, 1);
    end
    cyc();
    pushx("sat_stall_end", 0, 0, 0, E_RF, E_RF, 0, 15, 1);
    for (int k = 0; k < 18; k++) begin
      cyc(); ex_branch_taken = 1;
      pushx("sat_flush", 0, 1, 1, E_RF, E_RF, 0, 15, (k + 1 > 15) ? 15 : k + 1);
    end
    cyc();
    pushx("sat_flush_end", 0, 0, 0, E_RF, E_RF, 0, 15, 15);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
